// File: rtl/inbuf_pkg.sv
// Shared sizing constants for the compute core's stream buffers.
// NUM sets the signed stream width ([NUM:0]); INBUF_DEPTH is the default
// buffer depth used by both the input-side and output-side buffers.
package inbuf_pkg;

  localparam int NUM         = 15;
  localparam int INBUF_DEPTH = 4;

endpackage : inbuf_pkg

// File: rtl/inbuf.sv
// Input-side elastic buffer between an upstream producer and the compute core.
// Small circular FIFO using the valid/stop handshake on both sides. Every
// status output is decoded from registered state only, so the core's stop
// never reaches the upstream stop within a cycle. A full buffer therefore
// refuses a push even when the core pops on the same edge.
module inbuf
  import inbuf_pkg::*;
#(
  parameter int DW    = NUM + 1,
  parameter int DEPTH = INBUF_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] idata,
  input  logic                 ivalid,
  output logic                 istop,
  output logic signed [DW-1:0] cdata,
  output logic                 cvalid,
  input  logic                 cstop,
  output logic [LW-1:0]        level
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic signed [DW-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic                 push;
  logic                 pop;

  // Status decode and handshake qualification from registered state.
  always_comb begin
    level  = count;
    istop  = (count == FULL_LVL);
    cvalid = (count != {LW{1'b0}});
    if (count != {LW{1'b0}}) begin
      cdata = mem[rd_ptr];
    end else begin
      cdata = {DW{1'b0}};
    end
    push = ivalid && !istop;
    pop  = cvalid && !cstop;
  end

  // Storage array: written only on push edges, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= idata;
    end
  end

  // Pointers and occupancy; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {LW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : inbuf

// File: tb/tb_inbuf.sv
// Directed plus random bench for inbuf with a queue scoreboard.
module tb_inbuf;
  import inbuf_pkg::*;

  localparam int DW    = NUM + 1;
  localparam int DEPTH = INBUF_DEPTH;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] idata;
  logic                 ivalid;
  logic                 istop;
  logic signed [DW-1:0] cdata;
  logic                 cvalid;
  logic                 cstop;
  logic [LW-1:0]        level;

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] q[$];

  logic                 hold_prev = 1'b0;
  logic signed [DW-1:0] cdata_prev = '0;

  always #5 clk = ~clk;

  inbuf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .idata (idata),
    .ivalid(ivalid),
    .istop (istop),
    .cdata (cdata),
    .cvalid(cvalid),
    .cstop (cstop),
    .level (level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the scoreboard, update model.
  task automatic cyc(input logic iv, input logic signed [DW-1:0] d, input logic cs);
    int n;
    logic mpush;
    logic mpop;
    ivalid = iv;
    idata  = d;
    cstop  = cs;
    @(negedge clk);
    n = q.size();
    chk("level", 64'(level), 64'(n));
    chk("istop", 64'(istop), 64'(n == DEPTH));
    chk("cvalid", 64'(cvalid), 64'(n != 0));
    if (n != 0) chk("cdata", 64'(cdata), 64'(q[0]));
    else        chk("cdata_empty", 64'(cdata), 64'(0));
    mpush = iv && (n != DEPTH);
    mpop  = (n != 0) && !cs;
    if (mpop)  void'(q.pop_front());
    if (mpush) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Bounds and hold-stability properties sampled every falling edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      assert (level <= LW'(DEPTH)) else begin
        errors++;
        $error("FAIL level_bound observed=%0d expected<=%0d", level, DEPTH);
      end
      if (hold_prev) begin
        checks++;
        assert (cdata === cdata_prev) else begin
          errors++;
          $error("FAIL cdata_hold observed=%0h expected=%0h", cdata, cdata_prev);
        end
      end
    end
    hold_prev  <= (reset === 1'b1) && (cvalid === 1'b1) && (cstop === 1'b1);
    cdata_prev <= cdata;
  end

  initial begin
    logic signed [DW-1:0] vmin;
    logic signed [DW-1:0] vmax;
    logic signed [DW-1:0] v;
    int sel;
    vmin = {1'b1, {NUM{1'b0}}};
    vmax = {1'b0, {NUM{1'b1}}};

    reset  = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    cstop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_istop", 64'(istop), 64'(0));
    chk("rst_cvalid", 64'(cvalid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_cdata", 64'(cdata), 64'(0));
    reset = 1'b1;

    // Single word: -5 pushed, visible one cycle later, then popped.
    cyc(1'b1, -16'sd5, 1'b0);
    cyc(1'b0, 'x, 1'b0);
    cyc(1'b0, 'x, 1'b0);

    // Fill to full with core stalled; 14 held while full.
    for (int i = 10; i < 14; i++) cyc(1'b1, DW'(i), 1'b1);
    cyc(1'b1, DW'(14), 1'b1);
    cyc(1'b1, DW'(14), 1'b1);
    // Pop while full: 14 refused this edge, pushed the next.
    cyc(1'b1, DW'(14), 1'b0);
    cyc(1'b1, DW'(14), 1'b1);
    cyc(1'b0, 'x, 1'b1);
    repeat (5) cyc(1'b0, 'x, 1'b0);

    // Continuous streaming with pointer wrap.
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(i), 1'b0);
    repeat (3) cyc(1'b0, 'x, 1'b0);

    // Random backpressure with extreme signed values.
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      v = vmin;
      else if (sel == 1) v = vmax;
      else               v = DW'($urandom);
      cyc(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 2) == 0));
    end
    repeat (DEPTH + 2) cyc(1'b0, 'x, 1'b0);
    chk("drain_empty", 64'(q.size()), 64'(0));

    // Asynchronous reset mid-stream at level 3.
    for (int i = 1; i <= 3; i++) cyc(1'b1, DW'(i), 1'b1);
    ivalid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_istop", 64'(istop), 64'(0));
    chk("arst_cvalid", 64'(cvalid), 64'(0));
    chk("arst_level", 64'(level), 64'(0));
    q.delete();
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, DW'(7), 1'b0);
    cyc(1'b0, 'x, 1'b0);
    cyc(1'b0, 'x, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_inbuf

// File: doc/inbuf.md
Name: inbuf

Overview:
- Input-side elastic buffer: receives a stream from an upstream producer using the valid/stop handshake and presents it to a compute core.
- Mirror of the core's output stage: same handshake, opposite end, so producer-side stop is driven here and consumer-side stop is sampled here.
- Small circular FIFO. The upstream stop is derived only from registered state, so there is no combinational path from the core's stop to the upstream stop.

Parameters:
- DW, NUM+1: data width; matches the signed [NUM:0] stream width from def.svh.
- DEPTH, 4: number of entries; a power of two, at least 2.
- LW, $clog2(DEPTH)+1: occupancy width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- idata  in  DW signed  upstream data.
- ivalid  in  1  upstream data valid.
- istop  out  1  stop to upstream; upstream must hold idata/ivalid while high.
- cdata  out  DW signed  data to core (head entry).
- cvalid  out  1  head entry valid.
- cstop  in  1  core cannot accept this cycle.
- level  out  LW  current occupancy, 0..DEPTH.

Behaviour:
- Transfer rules:
  - Push occurs on a clock edge where ivalid && !istop.
  - Pop occurs on a clock edge where cvalid && !cstop.
- Reset (reset==0, asynchronous, no clock needed):
  - wr_ptr=0, rd_ptr=0, level=0.
  - istop=0, cvalid=0, cdata=0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all entries. The first edge after deassertion behaves as empty.
- Status signals, all combinational from registered state only:
  - istop = (level==DEPTH).
  - cvalid = (level!=0).
  - cdata = mem[rd_ptr] when level!=0; otherwise 0.
- Latency: a word pushed into an empty buffer at edge N appears on cdata with cvalid=1 after edge N (one cycle). There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained whenever 0<level<DEPTH.
- Pointers: log2(DEPTH) bits, increment on push/pop, wrap DEPTH-1 -> 0 naturally.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full (level==DEPTH): istop=1. Push is refused even if the core pops the same cycle; istop deasserts the cycle after the pop. This is deliberate: it removes the cstop->istop combinational path.
- Empty (level==0): cvalid=0. cstop is ignored and no pop occurs.
- ivalid while istop=1: no state change; upstream holds its word.
- Upstream data is sampled only on push edges. idata when ivalid=0 is ignored, including X.
- Signed data is stored and forwarded bit-exact; no arithmetic on the payload.
- Assertions (bench):
  - level never exceeds DEPTH and never underflows.
  - cdata is stable while cvalid && cstop.
  - No X on istop, cvalid or level after reset.

Decomposition:
- def.svh already supplies NUM. Add a shared constant for the default buffer depth (INBUF_DEPTH=4) there, so the core's inbuf and outbuf sizing lives in one place.
- No typedefs required.
- Single module. The storage array, pointers and level counter are inline. A separate sub-module is not warranted at this size.

Test Plan:
- Reset then single word: push idata=-5 at edge 1, cstop=0 -> cvalid=1, cdata=-5 after edge 1; popped at edge 2; level 0->1->0.
- Fill: cstop=1, push 10,11,12,13 -> level=4, istop=1 after the 4th edge; a 5th word (14) stays held with no state change; cdata=10 throughout.
- Full with simultaneous pop: at level=4, drop cstop for one cycle while ivalid=1 -> 10 popped, 14 not pushed, level=3, istop=0 next cycle; 14 pushed the following edge, level=4.
- Streaming and wrap: ivalid=1, cstop=0 continuously for 20 words 0..19 -> output sequence 0..19 in order, one per cycle after a 1-cycle lag; level holds at 1; pointers wrap at least 4 times.
- Random backpressure: random ivalid/cstop for 1000 cycles with signed values including -2^NUM and 2^NUM-1 -> scoreboard order/values exact; no loss, no duplication.
- Async reset mid-stream: at level=3, pull reset low between edges -> istop=0, cvalid=0, level=0 immediately; after release, the next push of 7 is the first output.
